// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state, next-PC source encodings and the default trap vector
package pc_seq_pkg;
    typedef enum logic {ST_RUN, ST_HALT} state_t;
    typedef enum logic [2:0] {
        SRC_SEQ, SRC_HOLD, SRC_BR, SRC_JMP, SRC_RET, SRC_TRAP, SRC_ERET
    } src_t;
    localparam logic [15:0] DEF_TRAP_VECTOR = 16'h0004;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; overflow overwrites the oldest entry
module ras_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PONE = 1;
    localparam logic [CW-1:0] CONE = 1;
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [CW-1:0] count;
    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);
    assign top   = mem[ptr - PONE];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem   <= '{default: '0};
            ptr   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            err <= (push && full) || (pop && empty);
            if (push) begin
                mem[ptr] <= push_data;
                ptr      <= ptr + PONE;
                if (!full) count <= count + CONE;
            end else if (pop && !empty) begin
                ptr   <= ptr - PONE;
                count <= count - CONE;
            end
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage next-PC priority mux with RUN/HALT FSM, RAS and epc
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int INST_ADDR_WIDTH = 16,
    parameter int RAS_DEPTH = 4,
    parameter logic [INST_ADDR_WIDTH-1:0] TRAP_VECTOR = INST_ADDR_WIDTH'(DEF_TRAP_VECTOR)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INST_ADDR_WIDTH-1:0] pc_cur,
    input  logic                       stall,
    input  logic                       branch_taken,
    input  logic [INST_ADDR_WIDTH-1:0] branch_target,
    input  logic                       jump,
    input  logic                       call,
    input  logic [INST_ADDR_WIDTH-1:0] jump_target,
    input  logic                       ret,
    input  logic                       trap,
    input  logic                       eret,
    input  logic                       halt_req,
    input  logic                       resume,
    output logic [INST_ADDR_WIDTH-1:0] pc_next,
    output logic                       redirect,
    output logic [INST_ADDR_WIDTH-1:0] epc,
    output logic                       halted,
    output logic                       ras_empty,
    output logic                       ras_full,
    output logic                       ras_err
);
    localparam logic [INST_ADDR_WIDTH-1:0] ONE = 1;
    state_t state, state_nx;
    src_t   src;
    logic   run, push, pop;
    logic [INST_ADDR_WIDTH-1:0] pc_inc, ras_top;
    assign pc_inc = pc_cur + ONE;
    assign run    = state == ST_RUN;
    assign halted = state == ST_HALT;
    assign pop    = run && !trap && !stall && !eret && ret;
    assign push   = run && !trap && !stall && !eret && !ret && call;
    always_comb begin
        src = trap            ? SRC_TRAP :
              !run || stall   ? SRC_HOLD :
              eret            ? SRC_ERET :
              ret             ? (ras_empty ? SRC_SEQ : SRC_RET) :
              call || jump    ? SRC_JMP :
              branch_taken    ? SRC_BR : SRC_SEQ;
        pc_next = '0;
        if (rst)
            case (src)
                SRC_TRAP: pc_next = TRAP_VECTOR;
                SRC_HOLD: pc_next = pc_cur;
                SRC_ERET: pc_next = epc;
                SRC_RET:  pc_next = ras_top;
                SRC_JMP:  pc_next = jump_target;
                SRC_BR:   pc_next = branch_target;
                default:  pc_next = pc_inc;
            endcase
        state_nx = run ? ((halt_req && !trap) ? ST_HALT : ST_RUN)
                       : ((resume || trap) ? ST_RUN : ST_HALT);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            redirect <= 1'b0;
            epc      <= '0;
        end else begin
            state    <= state_nx;
            redirect <= src != SRC_SEQ && src != SRC_HOLD;
            if (trap) epc <= pc_cur;
        end
    end
    ras_stack #(.W(INST_ADDR_WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(pc_inc),
        .top(ras_top), .empty(ras_empty), .full(ras_full), .err(ras_err)
    );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
    logic        clk = 0, rst = 0;
    logic [15:0] pc_cur = 0, branch_target = 0, jump_target = 0;
    logic        stall = 0, branch_taken = 0, jump = 0, call = 0, ret = 0;
    logic        trap = 0, eret = 0, halt_req = 0, resume = 0;
    logic [15:0] pc_next, epc;
    logic        redirect, halted, ras_empty, ras_full, ras_err;
    int checks = 0, failures = 0;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .call(call), .jump_target(jump_target), .ret(ret),
        .trap(trap), .eret(eret), .halt_req(halt_req), .resume(resume),
        .pc_next(pc_next), .redirect(redirect), .epc(epc), .halted(halted),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
        trap = 0; eret = 0; halt_req = 0; resume = 0;
    endtask

    task automatic test_reset();
        tick(); rst = 1;
        pc_cur = 16'h0040; call = 1; jump_target = 16'h0080;
        tick(); idle(); trap = 1;
        tick(); idle(); halt_req = 1;
        tick(); idle();
        checks++;
        if (halted !== 1'b1 || epc !== 16'h0040 || ras_empty !== 1'b0) begin
            failures++;
            $display("FAIL reset_pre halted=%b epc=%h empty=%b exp 1 0040 0", halted, epc, ras_empty);
        end
        #2 rst = 0;
        #1;
        checks++;
        if (pc_next !== 16'h0 || halted !== 1'b0 || ras_empty !== 1'b1 || epc !== 16'h0 ||
            ras_full !== 1'b0 || redirect !== 1'b0 || ras_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_async pc_next=%h halted=%b empty=%b epc=%h full=%b redir=%b err=%b exp 0000 0 1 0000 0 0 0",
                     pc_next, halted, ras_empty, epc, ras_full, redirect, ras_err);
        end
        tick(); tick(); rst = 1;
    endtask

    task automatic test_seq_branch();
        idle(); pc_cur = 16'h0010;
        #1; checks++;
        if (pc_next !== 16'h0011) begin failures++; $display("FAIL seq pc_next=%h exp 0011", pc_next); end
        tick(); checks++;
        if (redirect !== 1'b0) begin failures++; $display("FAIL seq_redirect got %b exp 0", redirect); end
        branch_taken = 1; branch_target = 16'h0100;
        #1; checks++;
        if (pc_next !== 16'h0100) begin failures++; $display("FAIL branch pc_next=%h exp 0100", pc_next); end
        tick(); idle(); checks++;
        if (redirect !== 1'b1) begin failures++; $display("FAIL branch_redirect got %b exp 1", redirect); end
        tick(); checks++;
        if (redirect !== 1'b0) begin failures++; $display("FAIL redirect_pulse got %b exp 0", redirect); end
    endtask

    task automatic test_call_ret();
        for (int i = 0; i < 5; i++) begin
            idle(); pc_cur = 16'h0020 + 16'(i); call = 1; jump_target = 16'h0200;
            #1; checks++;
            if (pc_next !== 16'h0200) begin failures++; $display("FAIL call%0d pc_next=%h exp 0200", i, pc_next); end
            tick(); checks++;
            if (ras_err !== (i == 4) || ras_full !== (i >= 3) || redirect !== 1'b1) begin
                failures++;
                $display("FAIL call%0d err=%b full=%b redir=%b exp %b %b 1", i, ras_err, ras_full, redirect, i == 4, i >= 3);
            end
        end
        for (int i = 0; i < 4; i++) begin
            idle(); pc_cur = 16'h0300; ret = 1;
            #1; checks++;
            if (pc_next !== 16'h0025 - 16'(i)) begin
                failures++; $display("FAIL ret%0d pc_next=%h exp %h", i, pc_next, 16'h0025 - 16'(i));
            end
            tick(); checks++;
            if (ras_err !== 1'b0 || redirect !== 1'b1) begin
                failures++; $display("FAIL ret%0d err=%b redir=%b exp 0 1", i, ras_err, redirect);
            end
        end
        idle(); pc_cur = 16'h0300; ret = 1;
        #1; checks++;
        if (pc_next !== 16'h0301) begin failures++; $display("FAIL ret_empty pc_next=%h exp 0301", pc_next); end
        tick(); idle(); checks++;
        if (ras_err !== 1'b1 || redirect !== 1'b0 || ras_empty !== 1'b1) begin
            failures++; $display("FAIL ret_empty err=%b redir=%b empty=%b exp 1 0 1", ras_err, redirect, ras_empty);
        end
        tick(); checks++;
        if (ras_err !== 1'b0) begin failures++; $display("FAIL ras_err_pulse got %b exp 0", ras_err); end
    endtask

    task automatic test_trap();
        idle(); pc_cur = 16'h0033; trap = 1; stall = 1; jump = 1; jump_target = 16'h0999;
        #1; checks++;
        if (pc_next !== 16'h0004) begin failures++; $display("FAIL trap pc_next=%h exp 0004", pc_next); end
        tick(); idle(); checks++;
        if (epc !== 16'h0033 || redirect !== 1'b1) begin
            failures++; $display("FAIL trap_epc epc=%h redir=%b exp 0033 1", epc, redirect);
        end
        pc_cur = 16'h0004; tick();
        pc_cur = 16'h0010; eret = 1;
        #1; checks++;
        if (pc_next !== 16'h0033) begin failures++; $display("FAIL eret pc_next=%h exp 0033", pc_next); end
        tick(); idle(); checks++;
        if (redirect !== 1'b1 || epc !== 16'h0033) begin
            failures++; $display("FAIL eret_post redir=%b epc=%h exp 1 0033", redirect, epc);
        end
    endtask

    task automatic test_halt();
        idle(); pc_cur = 16'h0050; halt_req = 1;
        #1; checks++;
        if (pc_next !== 16'h0051) begin failures++; $display("FAIL halt_req pc_next=%h exp 0051", pc_next); end
        tick(); idle(); checks++;
        if (halted !== 1'b1) begin failures++; $display("FAIL halt_enter halted=%b exp 1", halted); end
        jump = 1; jump_target = 16'h0777;
        for (int i = 0; i < 5; i++) begin
            #1; checks++;
            if (pc_next !== 16'h0050 || halted !== 1'b1) begin
                failures++; $display("FAIL halt_hold%0d pc_next=%h halted=%b exp 0050 1", i, pc_next, halted);
            end
            tick();
        end
        idle(); resume = 1; halt_req = 1;
        tick(); idle(); checks++;
        if (halted !== 1'b0 || pc_next !== 16'h0051) begin
            failures++; $display("FAIL resume halted=%b pc_next=%h exp 0 0051", halted, pc_next);
        end
        halt_req = 1; tick(); idle(); trap = 1;
        #1; checks++;
        if (halted !== 1'b1 || pc_next !== 16'h0004) begin
            failures++; $display("FAIL halt_trap halted=%b pc_next=%h exp 1 0004", halted, pc_next);
        end
        tick(); idle(); checks++;
        if (halted !== 1'b0 || epc !== 16'h0050 || redirect !== 1'b1) begin
            failures++; $display("FAIL trap_wake halted=%b epc=%h redir=%b exp 0 0050 1", halted, epc, redirect);
        end
    endtask

    task automatic test_wrap();
        idle(); pc_cur = 16'hFFFF;
        #1; checks++;
        if (pc_next !== 16'h0000) begin failures++; $display("FAIL wrap pc_next=%h exp 0000", pc_next); end
        tick(); checks++;
        if (redirect !== 1'b0) begin failures++; $display("FAIL wrap_redirect got %b exp 0", redirect); end
        call = 1; jump_target = 16'h0100;
        tick(); idle(); pc_cur = 16'h0100; ret = 1;
        #1; checks++;
        if (pc_next !== 16'h0000) begin failures++; $display("FAIL wrap_push pc_next=%h exp 0000", pc_next); end
        tick(); idle(); checks++;
        if (ras_empty !== 1'b1 || ras_err !== 1'b0) begin
            failures++; $display("FAIL wrap_pop empty=%b err=%b exp 1 0", ras_empty, ras_err);
        end
    endtask

    initial begin
        test_reset();
        test_seq_branch();
        test_call_ret();
        test_trap();
        test_halt();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the fetch stage. It drives the pc register's next-address input (pc_next) and observes its current value (pc_cur).
- Selects among sequential, branch, jump, call, return, trap-entry and trap-return addresses.
- Handles stall and halt.
- Owns a small return-address stack (RAS) and the exception PC (epc).
- Sits between the decode/execute control signals and the pc register.

Parameters:
INST_ADDR_WIDTH, 16, width of every instruction address.
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2).
TRAP_VECTOR, 16'h0004, address loaded on trap entry.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-low.
pc_cur  in  INST_ADDR_WIDTH  current PC from the pc register.
stall  in  1  hold PC this cycle.
branch_taken  in  1  conditional branch resolved taken.
branch_target  in  INST_ADDR_WIDTH  branch destination.
jump  in  1  unconditional jump to jump_target.
call  in  1  jump to jump_target and push pc_cur+1.
jump_target  in  INST_ADDR_WIDTH  jump/call destination.
ret  in  1  pop RAS, go to popped address.
trap  in  1  exception/interrupt request.
eret  in  1  return from trap to epc.
halt_req  in  1  enter HALT.
resume  in  1  leave HALT.
pc_next  out  INST_ADDR_WIDTH  next PC, to pc register input.
redirect  out  1  registered pulse: previous cycle's pc_next was non-sequential (flush fetch).
epc  out  INST_ADDR_WIDTH  saved trap return address.
halted  out  1  FSM is in HALT.
ras_empty  out  1  RAS holds 0 entries.
ras_full  out  1  RAS holds RAS_DEPTH entries.
ras_err  out  1  registered pulse on RAS underflow or overflow.

Behaviour:
- pc_next is combinational from inputs, pc_cur and state; all state updates on posedge clk.
- Reset (rst=0, async):
  - FSM=RUN, RAS count=0, pointer=0, entries=0, epc=0.
  - redirect=0, ras_err=0, halted=0, ras_empty=1, ras_full=0.
  - pc_next=0 while rst=0.
- FSM states:
  - RUN: halt_req (no trap) -> HALT next cycle.
  - HALT: resume -> RUN; trap -> RUN with vectoring (trap wakes the core).
- Priority in RUN, highest first:
  1. trap: pc_next=TRAP_VECTOR, epc<=pc_cur.
  2. stall: pc_next=pc_cur; all other requests ignored, no RAS/epc change.
  3. eret: pc_next=epc.
  4. ret: pc_next=RAS top, pop.
  5. call: pc_next=jump_target, push pc_cur+1.
  6. jump: pc_next=jump_target.
  7. branch_taken: pc_next=branch_target.
  8. otherwise: pc_next=pc_cur+1.
- In HALT: pc_next=pc_cur unless trap.
- Trap while stall or HALT: trap still wins; epc<=pc_cur.
- Arithmetic: pc_cur+1 is modulo 2^INST_ADDR_WIDTH; 16'hFFFF+1=16'h0000, no flag.
- redirect<=1 the cycle after any priority level 1 or 3-7 taken-path selection (trap, eret, ret, call, jump, branch), including a target equal to pc_cur+1; 0 otherwise.
- RAS rules:
  - Circular buffer, pointer modulo RAS_DEPTH.
  - Push when full: overwrite oldest entry, count stays RAS_DEPTH, ras_err pulse.
  - ret when empty: pc_next=pc_cur+1, no pointer change, ras_err pulse, redirect=0.
  - call and ret asserted together: ret wins by priority; call is ignored (no push).
- epc changes only on trap.
- halt_req and resume both asserted in HALT: resume wins. In RUN, resume is ignored.
- halt_req with a redirect in the same cycle: the redirect is performed, and HALT holds the new PC.

Decomposition:
- Shared package pc_seq_pkg holds:
  - FSM state encoding (ST_RUN, ST_HALT).
  - Next-PC source select encoding (SRC_SEQ, SRC_HOLD, SRC_BR, SRC_JMP, SRC_RET, SRC_TRAP, SRC_ERET).
  - Default TRAP_VECTOR constant.
- One natural sub-module: ras_stack (push/pop, circular pointer, count, empty/full, overflow/underflow), instantiated once.
- Priority mux and FSM live in pc_sequencer.

Test Plan:
- Reset mid-run: pc_cur=16'h0040, drop rst asynchronously -> pc_next=0, halted=0, ras_empty=1, epc=0 immediately, without waiting for a clock edge.
- Sequential then branch: pc_cur=16'h0010 idle -> pc_next=16'h0011, redirect=0. branch_taken=1, target=16'h0100 -> pc_next=16'h0100, redirect=1 next cycle.
- Call/return nesting, RAS_DEPTH=4:
  - Five calls at pc_cur=16'h0020..0024 -> ras_full=1, ras_err pulse on the 5th push.
  - Four rets -> pc_next = 16'h0025, 0024, 0023, 0022.
  - 5th ret -> ras_err pulse, pc_next=pc_cur+1.
- Trap priority: trap=1 with stall=1, jump=1, pc_cur=16'h0033 -> pc_next=16'h0004, epc=16'h0033 after the edge. Later eret -> pc_next=16'h0033.
- Halt/resume: halt_req at pc_cur=16'h0050 -> halted=1 next cycle, pc_next holds 16'h0050 for 5 cycles; resume -> pc_next=16'h0051. Repeat with trap in HALT -> pc_next=16'h0004, halted=0.
- Wrap-around: pc_cur=16'hFFFF idle -> pc_next=16'h0000, redirect=0. call at 16'hFFFF pushes 16'h0000.
